// File: rtl/tow_pkg.sv
// -----------------------------------------------------------------------------
// tow_pkg -- shared definitions for the tug-of-war round arbiter.
//   state_e     : round FSM encoding (IDLE=0, DARK=1, ARMED=2, HOLD=3)
//   LFSR_TAPS   : feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   LEFT/RIGHT  : winner encodings
//   pos_w()     : marker position width for a given number of positions
// -----------------------------------------------------------------------------
package tow_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DARK  = 2'd1,
    ARMED = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Taps 8,6,5,4 map to bit indices 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  function automatic int pos_w(input int n_pos);
    return (n_pos > 2) ? $clog2(n_pos) : 1;
  endfunction

endpackage

// File: rtl/round_arbiter_if.sv
// -----------------------------------------------------------------------------
// round_arbiter_if -- bundle between master controller / players and the
// round arbiter.
//   slowen, clear, pbl, pbr          : controller/player -> arbiter
//   rout, winrnd, pos, game_over,
//   winner                           : arbiter -> controller/LEDs
// Modports: master (controller side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface round_arbiter_if #(
  parameter int POS_W = 4
);
  logic             slowen;
  logic             clear;
  logic             pbl;
  logic             pbr;
  logic             rout;
  logic             winrnd;
  logic [POS_W-1:0] pos;
  logic             game_over;
  logic             winner;

  modport master (
    output slowen, clear, pbl, pbr,
    input  rout, winrnd, pos, game_over, winner
  );

  modport slave (
    input  slowen, clear, pbl, pbr,
    output rout, winrnd, pos, game_over, winner
  );
endinterface

// File: rtl/rnd_lfsr.sv
// -----------------------------------------------------------------------------
// rnd_lfsr -- free-running 8-bit Fibonacci LFSR (taps 8,6,5,4).
//   clk : system clock
//   rst : synchronous active-high reset, loads SEED (must be non-zero)
//   q   : current LFSR state
// -----------------------------------------------------------------------------
module rnd_lfsr
  import tow_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] lfsr_q, lfsr_d;

  // NOTE: every combinational output gets a value on every path; without it
  // the tool infers a latch to hold the old value.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // NOTE: flops use non-blocking assignment so every register samples the
  // pre-edge value of its sources, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/round_arbiter.sv
// -----------------------------------------------------------------------------
// round_arbiter -- per-round referee for the tug-of-war datapath.
// Generates a random dark interval, raises rout when it ends, arbitrates the
// two players' presses, moves the rope marker and flags game over.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : round_arbiter_if.slave (slowen, clear, pbl, pbr in;
//          rout, winrnd, pos, game_over, winner out)
// Build option: define FALSE_START_EN to award the point to the opponent when
// a player presses during the dark interval; otherwise such presses are
// ignored.
// -----------------------------------------------------------------------------
module round_arbiter
  import tow_pkg::*;
#(
  parameter int         N_POS     = 9,
  parameter int         MIN_DLY   = 4,
  parameter int         RND_BITS  = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic              clk,
  input logic              rst,
  round_arbiter_if.slave   bus
);

  localparam int POS_W = pos_w(N_POS);
  localparam int DLY_W = $clog2(MIN_DLY + 2**RND_BITS);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] POS_CTR = POS_W'((N_POS - 1) / 2);

  state_e           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             rout_q, rout_d;
  logic             winrnd_q, winrnd_d;
  logic             game_over_q, game_over_d;
  logic             winner_q, winner_d;

  logic             resolve;
  logic             step_up;
  logic             step_dn;

  logic [7:0]       lfsr_q;
  logic             unused_lfsr;

  rnd_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low RND_BITS of the LFSR feed the delay.
  assign unused_lfsr = ^lfsr_q[7:RND_BITS];

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    pos_d       = pos_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    winrnd_d    = 1'b0;
    resolve     = 1'b0;
    step_up     = 1'b0;
    step_dn     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.clear && !game_over_q) begin
          dly_d   = DLY_W'(MIN_DLY) + DLY_W'(lfsr_q[RND_BITS-1:0]);
          state_d = DARK;
        end
      end
      DARK: begin
        if (bus.clear) begin
          state_d = IDLE;
        end
`ifdef FALSE_START_EN
        // Early press gives the point to the opponent.
        else if (bus.pbl || bus.pbr) begin
          resolve = 1'b1;
          step_up = bus.pbl && !bus.pbr;
          step_dn = bus.pbr && !bus.pbl;
        end
`endif
        else if (bus.slowen) begin
          dly_d = dly_q - 1'b1;
          // This tick takes the counter to zero: the interval is over.
          if (dly_q <= DLY_W'(1)) state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.clear) begin
          state_d = IDLE;
        end else if (bus.pbl || bus.pbr) begin
          resolve = 1'b1;
          step_dn = bus.pbl && !bus.pbr;
          step_up = bus.pbr && !bus.pbl;
        end
      end
      HOLD: begin
        if (bus.clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (resolve) begin
      state_d  = HOLD;
      winrnd_d = 1'b1;
      if (step_up && pos_q != POS_MAX) pos_d = pos_q + 1'b1;
      if (step_dn && pos_q != '0)      pos_d = pos_q - 1'b1;
      if (pos_d == '0) begin
        game_over_d = 1'b1;
        winner_d    = LEFT;
      end else if (pos_d == POS_MAX) begin
        game_over_d = 1'b1;
        winner_d    = RIGHT;
      end
    end

    // rout is registered off the next state so it rises the cycle ARMED starts.
    rout_d = (state_d == ARMED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dly_q       <= '0;
      pos_q       <= POS_CTR;
      rout_q      <= 1'b0;
      winrnd_q    <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      pos_q       <= pos_d;
      rout_q      <= rout_d;
      winrnd_q    <= winrnd_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign bus.rout      = rout_q;
  assign bus.winrnd    = winrnd_q;
  assign bus.pos       = pos_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_round_arbiter.sv
// -----------------------------------------------------------------------------
// tb_round_arbiter -- directed self-checking bench for round_arbiter.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_round_arbiter;

  localparam int MIN_DLY = 4;
  localparam int CTR     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  round_arbiter_if #(.POS_W(4)) bus ();

  round_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   slow_cnt = 0;
  logic last_slow = 1'b0;

  // One clock: apply presses plus a slowen every fourth cycle, then wait for
  // the falling edge so outputs reflect the rising edge that took them.
  task automatic cycle(input logic l, input logic r);
    bus.pbl    = l;
    bus.pbr    = r;
    bus.slowen = (slow_cnt % 4 == 3);
    last_slow  = bus.slowen;
    slow_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.clear = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Drop clear and wait (bounded) for rout, checking the dark length.
  task automatic reach_armed(input string tag);
    int ticks = 0;
    bus.clear = 1'b0;
    cycle(1'b0, 1'b0);
    total++;
    if (bus.rout !== 1'b0) begin
      bad++; $display("FAIL %s rout_at_start: got %b want 0", tag, bus.rout);
    end
    for (int i = 0; i < 200 && bus.rout !== 1'b1; i++) begin
      cycle(1'b0, 1'b0);
      if (last_slow) ticks++;
    end
    total++;
    if (bus.rout !== 1'b1) begin
      bad++; $display("FAIL %s rout_timeout: got %b want 1", tag, bus.rout);
    end
    total++;
    if (ticks < MIN_DLY || ticks > MIN_DLY + 7) begin
      bad++; $display("FAIL %s dark_len: got %0d want %0d..%0d", tag, ticks, MIN_DLY, MIN_DLY + 7);
    end
  endtask

  task automatic new_round(input string tag);
    bus.clear = 1'b1;
    cycle(1'b0, 1'b0);
    reach_armed(tag);
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (bus.rout !== 1'b0)      begin bad++; $display("FAIL reset_rout: got %b want 0", bus.rout); end
    if (bus.winrnd !== 1'b0)    begin bad++; $display("FAIL reset_winrnd: got %b want 0", bus.winrnd); end
    if (bus.pos !== 4'(CTR))    begin bad++; $display("FAIL reset_pos: got %0d want %0d", bus.pos, CTR); end
    if (bus.game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over: got %b want 0", bus.game_over); end
    if (bus.winner !== 1'b0)    begin bad++; $display("FAIL reset_winner: got %b want 0", bus.winner); end
  endtask

  task automatic test_dark_interval();
    reach_armed("dark");
    total += 2;
    if (bus.pos !== 4'(CTR))  begin bad++; $display("FAIL dark_pos: got %0d want %0d", bus.pos, CTR); end
    if (bus.winrnd !== 1'b0)  begin bad++; $display("FAIL dark_winrnd: got %b want 0", bus.winrnd); end
  endtask

  task automatic test_tie();
    cycle(1'b1, 1'b1);
    total += 3;
    if (bus.winrnd !== 1'b1) begin bad++; $display("FAIL tie_winrnd: got %b want 1", bus.winrnd); end
    if (bus.pos !== 4'(CTR)) begin bad++; $display("FAIL tie_pos: got %0d want %0d", bus.pos, CTR); end
    if (bus.rout !== 1'b0)   begin bad++; $display("FAIL tie_rout: got %b want 0", bus.rout); end
    cycle(1'b0, 1'b0);
    total++;
    if (bus.winrnd !== 1'b0) begin bad++; $display("FAIL tie_winrnd_fall: got %b want 0", bus.winrnd); end
  endtask

  task automatic test_left_win();
    new_round("left");
    cycle(1'b1, 1'b0);
    total += 3;
    if (bus.winrnd !== 1'b1)    begin bad++; $display("FAIL left_winrnd: got %b want 1", bus.winrnd); end
    if (bus.pos !== 4'd3)       begin bad++; $display("FAIL left_pos: got %0d want 3", bus.pos); end
    if (bus.game_over !== 1'b0) begin bad++; $display("FAIL left_game_over: got %b want 0", bus.game_over); end
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_right_win();
    logic saw_rout = 1'b0;
    logic saw_win  = 1'b0;
    do_reset();
    reach_armed("right");
    cycle(1'b0, 1'b1);
    total += 3;
    if (bus.winrnd !== 1'b1) begin bad++; $display("FAIL right_winrnd: got %b want 1", bus.winrnd); end
    if (bus.pos !== 4'd5)    begin bad++; $display("FAIL right_pos: got %0d want 5", bus.pos); end
    if (bus.rout !== 1'b0)   begin bad++; $display("FAIL right_rout: got %b want 0", bus.rout); end
    cycle(1'b0, 1'b0);
    total++;
    if (bus.winrnd !== 1'b0) begin bad++; $display("FAIL right_winrnd_fall: got %b want 0", bus.winrnd); end
    // clear stays low: the round must stay parked in HOLD, presses ignored.
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, (i % 7 == 3));
      if (bus.rout === 1'b1)   saw_rout = 1'b1;
      if (bus.winrnd === 1'b1) saw_win  = 1'b1;
    end
    total += 3;
    if (saw_rout !== 1'b0) begin bad++; $display("FAIL hold_rout: got %b want 0", saw_rout); end
    if (saw_win !== 1'b0)  begin bad++; $display("FAIL hold_winrnd: got %b want 0", saw_win); end
    if (bus.pos !== 4'd5)  begin bad++; $display("FAIL hold_pos: got %0d want 5", bus.pos); end
    new_round("restart");
  endtask

  task automatic test_false_start();
    logic saw_rout = 1'b0;
    do_reset();
    bus.clear = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
`ifdef FALSE_START_EN
    total += 2;
    if (bus.winrnd !== 1'b1) begin bad++; $display("FAIL fs_winrnd: got %b want 1", bus.winrnd); end
    if (bus.pos !== 4'd5)    begin bad++; $display("FAIL fs_pos: got %0d want 5", bus.pos); end
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, 1'b0);
      if (bus.rout === 1'b1) saw_rout = 1'b1;
    end
    total++;
    if (saw_rout !== 1'b0) begin bad++; $display("FAIL fs_rout: got %b want 0", saw_rout); end
`else
    total += 2;
    if (bus.winrnd !== 1'b0) begin bad++; $display("FAIL fs_winrnd: got %b want 0", bus.winrnd); end
    if (bus.pos !== 4'(CTR)) begin bad++; $display("FAIL fs_pos: got %0d want %0d", bus.pos, CTR); end
    for (int i = 0; i < 80 && !saw_rout; i++) begin
      cycle(1'b0, 1'b0);
      if (bus.rout === 1'b1) saw_rout = 1'b1;
    end
    total += 2;
    if (saw_rout !== 1'b1)   begin bad++; $display("FAIL fs_rout: got %b want 1", saw_rout); end
    if (bus.pos !== 4'(CTR)) begin bad++; $display("FAIL fs_pos_after: got %0d want %0d", bus.pos, CTR); end
`endif
  endtask

  task automatic test_abort();
    logic saw_rout = 1'b0;
    logic saw_win  = 1'b0;
    do_reset();
    bus.clear = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    bus.clear = 1'b1;
    // Long clear: a DARK that failed to abort would raise rout here.
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b0);
      if (bus.rout === 1'b1)   saw_rout = 1'b1;
      if (bus.winrnd === 1'b1) saw_win  = 1'b1;
    end
    total += 2;
    if (saw_rout !== 1'b0) begin bad++; $display("FAIL abort_dark_rout: got %b want 0", saw_rout); end
    if (saw_win !== 1'b0)  begin bad++; $display("FAIL abort_dark_winrnd: got %b want 0", saw_win); end
    reach_armed("abort");
    bus.clear = 1'b1;
    cycle(1'b0, 1'b1);
    total += 3;
    if (bus.rout !== 1'b0)   begin bad++; $display("FAIL abort_armed_rout: got %b want 0", bus.rout); end
    if (bus.winrnd !== 1'b0) begin bad++; $display("FAIL abort_armed_winrnd: got %b want 0", bus.winrnd); end
    if (bus.pos !== 4'(CTR)) begin bad++; $display("FAIL abort_armed_pos: got %0d want %0d", bus.pos, CTR); end
    // Reset while ARMED with the marker off centre.
    new_round("pre_rst");
    cycle(1'b0, 1'b1);
    new_round("rst_armed");
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    rst = 1'b0;
    total += 2;
    if (bus.rout !== 1'b0)   begin bad++; $display("FAIL rst_armed_rout: got %b want 0", bus.rout); end
    if (bus.pos !== 4'(CTR)) begin bad++; $display("FAIL rst_armed_pos: got %0d want %0d", bus.pos, CTR); end
  endtask

  task automatic test_game_over();
    logic saw_rout = 1'b0;
    logic saw_win  = 1'b0;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      new_round("go");
      cycle(1'b0, 1'b1);
      total += 3;
      if (bus.winrnd !== 1'b1) begin bad++; $display("FAIL go_winrnd_%0d: got %b want 1", k, bus.winrnd); end
      if (bus.pos !== 4'(CTR + k)) begin bad++; $display("FAIL go_pos_%0d: got %0d want %0d", k, bus.pos, CTR + k); end
      if (bus.game_over !== (k == 4)) begin
        bad++; $display("FAIL go_flag_%0d: got %b want %b", k, bus.game_over, (k == 4));
      end
      cycle(1'b0, 1'b0);
    end
    total++;
    if (bus.winner !== 1'b1) begin bad++; $display("FAIL go_winner: got %b want 1", bus.winner); end
    for (int c = 0; c < 3; c++) begin
      bus.clear = 1'b1;
      cycle(1'b0, 1'b0);
      bus.clear = 1'b0;
      for (int i = 0; i < 40; i++) begin
        cycle((i % 5 == 1), (i % 5 == 2));
        if (bus.rout === 1'b1)   saw_rout = 1'b1;
        if (bus.winrnd === 1'b1) saw_win  = 1'b1;
      end
    end
    total += 4;
    if (saw_rout !== 1'b0)      begin bad++; $display("FAIL go_park_rout: got %b want 0", saw_rout); end
    if (saw_win !== 1'b0)       begin bad++; $display("FAIL go_park_winrnd: got %b want 0", saw_win); end
    if (bus.pos !== 4'd8)       begin bad++; $display("FAIL go_park_pos: got %0d want 8", bus.pos); end
    if (bus.game_over !== 1'b1) begin bad++; $display("FAIL go_park_flag: got %b want 1", bus.game_over); end
    do_reset();
    total += 2;
    if (bus.pos !== 4'(CTR))    begin bad++; $display("FAIL go_rst_pos: got %0d want %0d", bus.pos, CTR); end
    if (bus.game_over !== 1'b0) begin bad++; $display("FAIL go_rst_flag: got %b want 0", bus.game_over); end
  endtask

  initial begin
    rst        = 1'b1;
    bus.clear  = 1'b1;
    bus.pbl    = 1'b0;
    bus.pbr    = 1'b0;
    bus.slowen = 1'b0;
    @(negedge clk);
    test_reset();
    test_dark_interval();
    test_tie();
    test_left_win();
    test_right_win();
    test_false_start();
    test_abort();
    test_game_over();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/round_arbiter.md
Name: round_arbiter

Overview:
- Per-round referee for the tug-of-war datapath. Sits between the master controller and the player push-buttons / LED marker.
- Generates a random dark interval and raises `rout` when it ends.
- Arbitrates the two players' presses, detects false starts, and moves the rope marker.
- Pulses `winrnd` back to the master controller when a round resolves, and flags game over when the marker reaches either end.

Parameters:
- N_POS, 9, number of marker positions; centre = (N_POS-1)/2.
- MIN_DLY, 4, minimum dark interval in slowen ticks.
- RND_BITS, 3, LFSR bits added to MIN_DLY; dark interval range is MIN_DLY .. MIN_DLY+2^RND_BITS-1.
- LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- slowen  in  1  one-cycle slow tick enable
- clear  in  1  from master controller; 1 = round inactive/hold, 0 = round live
- pbl  in  1  left player press, debounced one-cycle pulse
- pbr  in  1  right player press, debounced one-cycle pulse
- rout  out  1  dark interval expired; pushes accepted
- winrnd  out  1  one-cycle pulse: round resolved
- pos  out  $clog2(N_POS)  marker position, 0 = left end
- game_over  out  1  sticky; marker reached an end
- winner  out  1  valid while game_over; 0 = left, 1 = right

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst; all state changes on posedge clk.
  - Reset values: state=IDLE, rout=0, winrnd=0, pos=centre, game_over=0, winner=0, LFSR=LFSR_SEED, delay counter=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk cycle, not gated by slowen, so the delay depends on button timing.
- IDLE:
  - Outputs: rout=0, winrnd=0.
  - Stays in IDLE while clear=1 or game_over=1.
  - When clear=0 and game_over=0: load dly = MIN_DLY + LFSR[RND_BITS-1:0], then go to DARK.
- DARK:
  - Decrements dly on each slowen.
  - When dly reaches 0 on a slowen cycle: go to ARMED; rout=1 from the next cycle.
  - Press in DARK is a false start, see Optional Feature.
- ARMED:
  - rout held at 1.
  - pbl alone: pos decrements; one-cycle winrnd pulse; go to HOLD.
  - pbr alone: pos increments; one-cycle winrnd pulse; go to HOLD.
  - pbl and pbr in the same cycle: tie; winrnd pulses, pos unchanged, go to HOLD.
- HOLD:
  - Outputs: rout=0.
  - Waits for clear=1, then returns to IDLE. A round cannot restart until the master controller has cycled clear.
- clear=1 mid-round (DARK or ARMED): abort to IDLE next cycle; no winrnd pulse, pos unchanged.
- Position and game end:
  - pos saturates in [0, N_POS-1].
  - pos=0 sets game_over=1, winner=0; pos=N_POS-1 sets game_over=1, winner=1. Both are set in the same cycle as the final winrnd pulse.
  - After game_over, presses are ignored and the FSM parks in IDLE until rst.
- winrnd is registered: asserted exactly one cycle after the resolving press; never asserted two consecutive cycles.
- Presses in IDLE or HOLD are ignored.

Optional Feature:
- Macro: FALSE_START_EN.
- Defined: a press in DARK awards the point to the opponent.
  - pbl early: pos increments.
  - pbr early: pos decrements.
  - Both early in the same cycle: tie, pos unchanged.
  - In all cases winrnd pulses and the FSM goes to HOLD.
- Undefined: presses in DARK are ignored and DARK continues counting.

Decomposition:
- Shared package tow_pkg:
  - state encoding: IDLE=0, DARK=1, ARMED=2, HOLD=3.
  - LFSR tap mask constant.
  - POS_W derivation helper.
  - LEFT/RIGHT winner constants.
- Sub-module rnd_lfsr:
  - ports: clk, rst, q[7:0].
  - seed parameter; free-running.
  - Instantiated once.

Test Plan:
- rst=1 for 2 cycles, then clear=0, slowen every 4 clk, no presses → DARK lasts MIN_DLY..MIN_DLY+7 slowen ticks, then rout=1; pos stays 4.
- Reach ARMED, pulse pbr → winrnd=1 exactly one cycle later, for one cycle; pos 4→5; rout falls; no new round until clear 1→0.
- Reach ARMED, pulse pbl and pbr in the same cycle → winrnd pulses once, pos unchanged at 4.
- With FALSE_START_EN defined, pulse pbl during DARK → pos 4→5, winrnd pulses, rout never rises. Without the macro → pos stays 4, rout rises on schedule.
- Four right wins from centre → pos reaches 8 with game_over=1 and winner=1 on the fourth winrnd; further presses and clear cycles leave pos=8; rst restores pos=4 and game_over=0.
- Raise clear during DARK → IDLE next cycle, no winrnd; rst asserted while ARMED → next cycle rout=0, pos=4.
